trig_conditioner: RTL and testbench

- Parametrised successor to the fixed two-way trigger select on the CW305 DesignStart top level.
- Selects one of pNUM_SRC trigger sources, e.g. M3 GPIO trigger and trace-match trigger.
- Drives trig_out either as a registered pass-through or as an armed, delayed, width-controlled pulse.
- Also provides a trigger event counter and a capture-quiet LED heartbeat counter; sits between trace_top and the trig_out/LED pins.

---
 rtl/trig_conditioner_pkg.sv | 16 +
 rtl/trig_pulse_gen.sv | 82 ++++++++
 rtl/trig_conditioner.sv | 86 ++++++++
 tb/tb_trig_conditioner.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/trig_conditioner_pkg.sv
// Shared constants for the trigger conditioner: FSM state codes and mode values.
package trig_conditioner_pkg;

  localparam int unsigned STATE_WIDTH = 2;

  typedef logic [STATE_WIDTH-1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t ARMED = 2'd1;
  localparam state_t DELAY = 2'd2;
  localparam state_t PULSE = 2'd3;

  localparam logic MODE_PASS  = 1'b0;
  localparam logic MODE_PULSE = 1'b1;

endpackage

// File: rtl/trig_pulse_gen.sv
// Armed/delayed/width-controlled pulse generator for the trigger conditioner.
module trig_pulse_gen
  import trig_conditioner_pkg::*;
#(
  parameter int unsigned pDELAY_WIDTH = 16,
  parameter int unsigned pPULSE_WIDTH = 16
) (
  input  logic                    ext_clock,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic                    arm,
  input  logic                    disarm,
  input  logic                    src,
  input  logic                    auto_rearm,
  input  logic [pDELAY_WIDTH-1:0] delay,
  input  logic [pPULSE_WIDTH-1:0] width,
  output logic                    pulse_c,
  output logic                    armed,
  output logic                    busy
);

  state_t                  state_q;
  state_t                  state_d;
  logic                    prev_q;
  logic [pDELAY_WIDTH-1:0] dly_q;
  logic [pDELAY_WIDTH-1:0] dly_d;
  logic [pPULSE_WIDTH-1:0] wid_q;
  logic [pPULSE_WIDTH-1:0] wid_d;

  // Next-state logic; abort or leaving pulse mode always returns to IDLE.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    wid_d   = wid_q;
    if (!enable || disarm) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm) state_d = ARMED;
        end
        ARMED: begin
          if (!prev_q && src) begin
            dly_d   = delay;
            wid_d   = (width == '0) ? pPULSE_WIDTH'(1) : width;
            state_d = (delay == '0) ? PULSE : DELAY;
          end
        end
        DELAY: begin
          if (dly_q <= pDELAY_WIDTH'(1)) state_d = PULSE;
          else                           dly_d   = dly_q - pDELAY_WIDTH'(1);
        end
        PULSE: begin
          if (wid_q <= pPULSE_WIDTH'(1)) state_d = auto_rearm ? ARMED : IDLE;
          else                           wid_d   = wid_q - pPULSE_WIDTH'(1);
        end
        default: state_d = IDLE;
      endcase
    end
    pulse_c = (state_d == PULSE);
  end

  // State, edge history (tracks the source every cycle) and status flags.
  always_ff @(posedge ext_clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      prev_q  <= 1'b0;
      dly_q   <= '0;
      wid_q   <= '0;
      armed   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= src;
      dly_q   <= dly_d;
      wid_q   <= wid_d;
      armed   <= (state_d == ARMED);
      busy    <= (state_d == DELAY) || (state_d == PULSE);
    end
  end

endmodule

// File: rtl/trig_conditioner.sv
// Trigger source select, pass-through/pulse output, event counter and heartbeat.
module trig_conditioner
  import trig_conditioner_pkg::*;
#(
  parameter int unsigned pNUM_SRC     = 4,
  parameter int unsigned pSEL_WIDTH   = 4,
  parameter int unsigned pDELAY_WIDTH = 16,
  parameter int unsigned pPULSE_WIDTH = 16,
  parameter int unsigned pCOUNT_WIDTH = 16,
  parameter int unsigned pHB_WIDTH    = 23
) (
  input  logic                    ext_clock,
  input  logic                    resetn,
  input  logic [pNUM_SRC-1:0]     I_src,
  input  logic [pSEL_WIDTH-1:0]   I_sel,
  input  logic                    I_mode,
  input  logic [pDELAY_WIDTH-1:0] I_delay,
  input  logic [pPULSE_WIDTH-1:0] I_width,
  input  logic                    I_auto_rearm,
  input  logic                    I_arm,
  input  logic                    I_disarm,
  input  logic                    I_clear,
  output logic                    O_trig,
  output logic                    O_armed,
  output logic                    O_busy,
  output logic [pCOUNT_WIDTH-1:0] O_count,
  output logic                    O_heartbeat
);

  logic                 sel_src_c;
  logic                 pulse_c;
  logic                 trig_d_c;
  logic [pHB_WIDTH-1:0] hb_q;

  // Source mux; out-of-range selects fall back to source 0.
  always_comb begin
    sel_src_c = I_src[0];
    for (int unsigned i = 0; i < pNUM_SRC; i++) begin
      if (I_sel == pSEL_WIDTH'(i)) sel_src_c = I_src[i];
    end
  end

  trig_pulse_gen #(
    .pDELAY_WIDTH (pDELAY_WIDTH),
    .pPULSE_WIDTH (pPULSE_WIDTH)
  ) u_pulse_gen (
    .ext_clock  (ext_clock),
    .resetn     (resetn),
    .enable     (I_mode == MODE_PULSE),
    .arm        (I_arm),
    .disarm     (I_disarm),
    .src        (sel_src_c),
    .auto_rearm (I_auto_rearm),
    .delay      (I_delay),
    .width      (I_width),
    .pulse_c    (pulse_c),
    .armed      (O_armed),
    .busy       (O_busy)
  );

  // Next trigger value for the selected mode.
  always_comb begin
    trig_d_c = (I_mode == MODE_PASS) ? sel_src_c : pulse_c;
  end

  // Registered trigger plus saturating count of its rising edges; clear wins.
  always_ff @(posedge ext_clock or negedge resetn) begin
    if (!resetn) begin
      O_trig  <= 1'b0;
      O_count <= '0;
    end else begin
      O_trig <= trig_d_c;
      if (I_clear)                                O_count <= '0;
      else if (trig_d_c && !O_trig && O_count != '1) O_count <= O_count + pCOUNT_WIDTH'(1);
    end
  end

  // Heartbeat runs only while the trigger is quiet.
  always_ff @(posedge ext_clock or negedge resetn) begin
    if (!resetn)      hb_q <= '0;
    else if (!O_trig) hb_q <= hb_q + pHB_WIDTH'(1);
  end

  assign O_heartbeat = hb_q[pHB_WIDTH-1];

endmodule

// File: tb/tb_trig_conditioner.sv
// Randomized bench for trig_conditioner against a window-based reference model.
module tb_trig_conditioner;

  localparam int unsigned NSRC = 4;
  localparam int unsigned SELW = 3;
  localparam int unsigned DW   = 4;
  localparam int unsigned WW   = 3;
  localparam int unsigned CW   = 4;
  localparam int unsigned HW   = 6;
  localparam int unsigned NCYC = 4000;

  logic            ext_clock = 1'b0;
  logic            resetn;
  logic [NSRC-1:0] I_src;
  logic [SELW-1:0] I_sel;
  logic            I_mode;
  logic [DW-1:0]   I_delay;
  logic [WW-1:0]   I_width;
  logic            I_auto_rearm;
  logic            I_arm;
  logic            I_disarm;
  logic            I_clear;
  logic            O_trig;
  logic            O_armed;
  logic            O_busy;
  logic [CW-1:0]   O_count;
  logic            O_heartbeat;

  trig_conditioner #(
    .pNUM_SRC     (NSRC),
    .pSEL_WIDTH   (SELW),
    .pDELAY_WIDTH (DW),
    .pPULSE_WIDTH (WW),
    .pCOUNT_WIDTH (CW),
    .pHB_WIDTH    (HW)
  ) u_dut (
    .ext_clock    (ext_clock),
    .resetn       (resetn),
    .I_src        (I_src),
    .I_sel        (I_sel),
    .I_mode       (I_mode),
    .I_delay      (I_delay),
    .I_width      (I_width),
    .I_auto_rearm (I_auto_rearm),
    .I_arm        (I_arm),
    .I_disarm     (I_disarm),
    .I_clear      (I_clear),
    .O_trig       (O_trig),
    .O_armed      (O_armed),
    .O_busy       (O_busy),
    .O_count      (O_count),
    .O_heartbeat  (O_heartbeat)
  );

  always #5 ext_clock = ~ext_clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: armed flag plus an absolute-cycle busy/pulse window.
  bit m_armed;
  bit m_win;
  bit m_prev;
  bit m_trig;
  int m_start;
  int m_end;
  int m_cyc;
  int m_count;
  int m_hb;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, m_cyc);
    end
  endtask

  function automatic void model_reset();
    m_armed = 1'b0;
    m_win   = 1'b0;
    m_prev  = 1'b0;
    m_trig  = 1'b0;
    m_start = 0;
    m_end   = 0;
    m_count = 0;
    m_hb    = 0;
  endfunction

  // Predicts outputs after the upcoming clock edge from the current inputs.
  function automatic void model_step();
    int  idx;
    int  wv;
    bit  sel;
    bit  new_trig;
    int  n;
    n   = m_cyc;
    idx = (int'(I_sel) < int'(NSRC)) ? int'(I_sel) : 0;
    sel = 1'(I_src >> idx);
    if (I_mode == 1'b0 || I_disarm) begin
      m_armed = 1'b0;
      m_win   = 1'b0;
    end else if (m_win) begin
      if (n == m_end) begin
        m_win   = 1'b0;
        m_armed = I_auto_rearm;
      end
    end else if (m_armed) begin
      if (!m_prev && sel) begin
        wv      = (I_width == '0) ? 1 : int'(I_width);
        m_armed = 1'b0;
        m_win   = 1'b1;
        m_start = n + 1 + int'(I_delay);
        m_end   = m_start + wv - 1;
      end
    end else if (I_arm) begin
      m_armed = 1'b1;
    end
    m_prev   = sel;
    new_trig = (I_mode == 1'b0) ? sel : (m_win && (n + 1 >= m_start));
    if (I_clear)                                   m_count = 0;
    else if (new_trig && !m_trig && m_count < 15)  m_count = m_count + 1;
    if (!m_trig) m_hb = (m_hb + 1) % 64;
    m_trig = new_trig;
    m_cyc  = m_cyc + 1;
  endfunction

  task automatic check_outputs();
    check_eq("trig",      32'(O_trig),      32'(m_trig));
    check_eq("armed",     32'(O_armed),     32'(m_armed));
    check_eq("busy",      32'(O_busy),      32'(m_win));
    check_eq("count",     32'(O_count),     32'(m_count));
    check_eq("heartbeat", 32'(O_heartbeat), 32'((m_hb >> 5) & 1));
  endtask

  task automatic drive_random();
    for (int b = 0; b < int'(NSRC); b++) begin
      if ($urandom_range(7, 0) == 0) I_src[b] = ~I_src[b];
    end
    if ($urandom_range(49, 0) == 0)  I_sel = SELW'($urandom_range(7, 0));
    if ($urandom_range(149, 0) == 0) I_mode = ~I_mode;
    if ($urandom_range(29, 0) == 0)  I_auto_rearm = ~I_auto_rearm;
    I_delay  = DW'($urandom_range(15, 0));
    I_width  = WW'($urandom_range(7, 0));
    I_arm    = ($urandom_range(7, 0) == 0);
    I_disarm = ($urandom_range(59, 0) == 0);
    I_clear  = ($urandom_range(299, 0) == 0);
  endtask

  task automatic async_reset(input string tag);
    resetn = 1'b0;
    #1;
    check_eq({tag, "_trig"},  32'(O_trig),  32'd0);
    check_eq({tag, "_armed"}, 32'(O_armed), 32'd0);
    check_eq({tag, "_busy"},  32'(O_busy),  32'd0);
    check_eq({tag, "_count"}, 32'(O_count), 32'd0);
    check_eq({tag, "_hb"},    32'(O_heartbeat), 32'd0);
    model_reset();
    @(negedge ext_clock);
    resetn = 1'b1;
  endtask

  initial begin
    bit pulse_reset_done;
    pulse_reset_done = 1'b0;
    m_cyc        = 0;
    resetn       = 1'b0;
    I_src        = '0;
    I_sel        = SELW'(1);
    I_mode       = 1'b1;
    I_delay      = '0;
    I_width      = '0;
    I_auto_rearm = 1'b0;
    I_arm        = 1'b0;
    I_disarm     = 1'b0;
    I_clear      = 1'b0;
    model_reset();
    repeat (2) @(negedge ext_clock);
    check_outputs();
    resetn = 1'b1;
    for (int i = 0; i < int'(NCYC); i++) begin
      drive_random();
      model_step();
      @(negedge ext_clock);
      check_outputs();
      if (!pulse_reset_done && i > 200 && m_trig && I_mode == 1'b1) begin
        pulse_reset_done = 1'b1;
        async_reset("rst_pulse");
      end else if (i == 2500) begin
        async_reset("rst_mid");
      end
    end
    check_eq("pulse_reset_seen", 32'(pulse_reset_done), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
